// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals of mem_arbiter.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_ack;
  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW-1:0]   d_rdata;
  logic            d_ack;
  logic            m_req;
  logic            m_we;
  logic [DW/8-1:0] m_be;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m_ready;
  logic            busy;
  logic            err;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ready,
    output if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_be, m_addr, m_wdata, busy, err
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata, m_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, m_req, m_we, m_be, m_addr, m_wdata, busy, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin fetch/data arbiter in front of one single-port memory.
// Define MEM_ARB_TIMEOUT_EN to abort a grant after TIMEOUT wait cycles with err.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;
  state_t          r_state, w_next;
  logic            r_last;
  logic            r_we;
  logic [DW/8-1:0] r_be;
  logic [AW-1:0]   r_addr;
  logic [DW-1:0]   r_wdata, r_if_rdata, r_d_rdata;
  logic            w_grant, w_pick_d, w_timeout, w_done;
  assign w_grant  = (r_state == GRANT_I) || (r_state == GRANT_D);
  // r_last is 1 when data won last, so a tie goes to the other port
  assign w_pick_d = bus.d_req && (!bus.if_req || !r_last);
  assign w_done   = w_grant && (bus.m_ready || w_timeout);
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(TIMEOUT - 1);
  logic [WW-1:0] r_wait;
  logic          r_err;
  assign w_timeout = w_grant && !bus.m_ready && (r_wait == LIMIT);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wait <= (w_grant && !bus.m_ready) ? r_wait + 1'b1 : '0;
      r_err  <= w_timeout;
    end
  end
  assign bus.err = r_err;
`else
  assign w_timeout = 1'b0;
  assign bus.err   = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = w_pick_d ? GRANT_D : bus.if_req ? GRANT_I : IDLE;
    else if (r_state == RESP) w_next = IDLE;
    else if (w_done) w_next = RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE) begin
        r_last  <= w_pick_d;
        r_we    <= w_pick_d && bus.d_we;
        r_be    <= w_pick_d ? bus.d_be : '1;
        r_addr  <= w_pick_d ? bus.d_addr : bus.if_addr;
        r_wdata <= w_pick_d ? bus.d_wdata : '0;
      end
      if (w_done && r_state == GRANT_I) r_if_rdata <= w_timeout ? '0 : bus.m_rdata;
      if (w_done && r_state == GRANT_D && (w_timeout || !r_we)) r_d_rdata <= w_timeout ? '0 : bus.m_rdata;
    end
  end
  assign bus.m_req    = w_grant;
  assign bus.m_we     = r_we;
  assign bus.m_be     = r_be;
  assign bus.m_addr   = r_addr;
  assign bus.m_wdata  = r_wdata;
  assign bus.if_rdata = r_if_rdata;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.if_ack   = (r_state == RESP) && !r_last;
  assign bus.d_ack    = (r_state == RESP) && r_last;
  assign bus.busy     = r_state != IDLE;
endmodule
